// File: rtl/ym_bus_writer.sv
// ym_bus_writer: queues YM2151 register writes and replays them on the chip CPU bus
// (address write, busy polling, data write). Define YM_BUS_WRITER_ADDR_CACHE_EN to skip repeated address writes.
module ym_bus_writer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 255,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                          phiM,
    input  logic                          IC_b,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic [7:0]                    Din,
    output logic                          CS_b,
    output logic                          WR_b,
    output logic                          RD_b,
    output logic                          A0,
    input  logic [7:0]                    Dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_err,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] POLL_MAX = PW'(BUSY_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_WR, POLL_A, POLL_B, SAMPLE, DATA_WR, RECOVER
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     level_reg;
    logic [15:0]     head;
    logic            push, pop, cache_hit, busy_flag;
    logic [7:0]      data_reg;
    logic [PW-1:0]   poll_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            timeout_err_reg;
    logic            cs_b_reg, wr_b_reg, rd_b_reg, a0_reg;
    logic            cs_b_next, wr_b_next, rd_b_next, a0_next;
    logic [7:0]      din_reg, din_next;
    logic            dout_unused;

    assign req_ready   = (level_reg != DEPTH);
    assign push        = req_valid && req_ready;
    assign pop         = (state_reg == IDLE) && (level_reg != '0);
    assign head        = fifo_mem[rd_ptr_reg];
    assign busy_flag   = Dout[7];
    assign dout_unused = ^Dout[6:0];

    always_ff @(posedge phiM) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {req_addr, req_data};
    end

    always_ff @(posedge phiM) begin
        if (!IC_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

`ifdef YM_BUS_WRITER_ADDR_CACHE_EN
    logic [7:0] last_addr_reg;
    logic       last_valid_reg;

    // During ADDR_WR the Din register is holding the register number just written.
    always_ff @(posedge phiM) begin
        if (!IC_b) begin
            last_addr_reg  <= '0;
            last_valid_reg <= 1'b0;
        end else if (state_reg == ADDR_WR) begin
            last_addr_reg  <= din_reg;
            last_valid_reg <= 1'b1;
        end
    end

    assign cache_hit = last_valid_reg && (last_addr_reg == head[15:8]);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge phiM) begin
        if (!IC_b)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = cache_hit ? POLL_A : ADDR_WR;
            ADDR_WR: state_next = POLL_A;
            POLL_A:  state_next = POLL_B;
            POLL_B:  state_next = SAMPLE;
            SAMPLE:  state_next = (!busy_flag || poll_cnt_reg == POLL_MAX) ? DATA_WR : POLL_A;
            DATA_WR: state_next = RECOVER;
            RECOVER: if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus values are derived from the state being entered so they can be registered
    // and still line up with the state that owns them.
    always_comb begin
        cs_b_next = 1'b1;
        wr_b_next = 1'b1;
        rd_b_next = 1'b1;
        a0_next   = a0_reg;
        din_next  = din_reg;
        case (state_next)
            ADDR_WR: begin
                cs_b_next = 1'b0;
                wr_b_next = 1'b0;
                a0_next   = 1'b0;
                din_next  = head[15:8];
            end
            POLL_A: begin
                cs_b_next = 1'b0;
                rd_b_next = 1'b0;
                a0_next   = 1'b0;
            end
            POLL_B: begin
                cs_b_next = 1'b0;
                rd_b_next = 1'b0;
            end
            DATA_WR: begin
                cs_b_next = 1'b0;
                wr_b_next = 1'b0;
                a0_next   = 1'b1;
                din_next  = data_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge phiM) begin
        if (!IC_b) begin
            cs_b_reg <= 1'b1;
            wr_b_reg <= 1'b1;
            rd_b_reg <= 1'b1;
            a0_reg   <= 1'b0;
            din_reg  <= '0;
        end else begin
            cs_b_reg <= cs_b_next;
            wr_b_reg <= wr_b_next;
            rd_b_reg <= rd_b_next;
            a0_reg   <= a0_next;
            din_reg  <= din_next;
        end
    end

    always_ff @(posedge phiM) begin
        if (!IC_b) begin
            data_reg        <= '0;
            poll_cnt_reg    <= '0;
            gap_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (pop)
                data_reg <= head[7:0];
            if (state_reg == SAMPLE && busy_flag && poll_cnt_reg != POLL_MAX)
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
            else if (state_reg == DATA_WR)
                poll_cnt_reg <= '0;
            gap_cnt_reg <= (state_reg == RECOVER) ? gap_cnt_reg + 1'b1 : '0;
            // A timeout in the same cycle as err_clr must stay visible.
            if (state_reg == SAMPLE && busy_flag && poll_cnt_reg == POLL_MAX)
                timeout_err_reg <= 1'b1;
            else if (err_clr)
                timeout_err_reg <= 1'b0;
        end
    end

    assign Din         = din_reg;
    assign CS_b        = cs_b_reg;
    assign WR_b        = wr_b_reg;
    assign RD_b        = rd_b_reg;
    assign A0          = a0_reg;
    assign fifo_level  = level_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = (state_reg != IDLE) || (level_reg != '0);

endmodule

// File: tb/tb_ym_bus_writer.sv
// Bench for ym_bus_writer: directed scenarios plus randomized requests, checked against a
// transaction-level model of expected bus writes, poll counts and FIFO occupancy.
module tb_ym_bus_writer;
    localparam int FD  = 8;
    localparam int BT  = 3;
    localparam int GAP = 1;

    logic       phiM = 1'b0;
    logic       IC_b = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [7:0] Din;
    logic       CS_b, WR_b, RD_b, A0;
    logic [7:0] Dout = '0;
    logic       busy;
    logic [$clog2(FD):0] fifo_level;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    ym_bus_writer #(.FIFO_DEPTH(FD), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)) dut (
        .phiM(phiM), .IC_b(IC_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .Din(Din), .CS_b(CS_b), .WR_b(WR_b),
        .RD_b(RD_b), .A0(A0), .Dout(Dout), .busy(busy), .fifo_level(fifo_level),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 phiM = ~phiM;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         busy_n;
        bit         addr_wr;
        bit         addr_seen;
        bit         started;
        int         t_addr;
    } req_t;

    req_t       req_q[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, pushes = 0, pops = 0, polls_seen = 0, rd_run = 0;
    int         addr_writes = 0, stalls = 0, max_level = 0, next_busy_n = 0;
    bit         model_err = 0, last_push = 0, cache_valid = 0;
    logic [7:0] cache_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        req_t h;
        int   exp_polls;
        bit   wr, rd, was_rd;
        wr = !CS_b && !WR_b;
        rd = !CS_b && !RD_b;
        was_rd = (rd_run != 0);
        if (wr && rd)
            chk("strobe_overlap", 1, 0);
        if ((wr || rd) && req_q.size() > 0 && !req_q[0].started) begin
            h = req_q[0];
            h.started = 1;
            req_q[0] = h;
            pops++;
        end
        rd_run = rd ? rd_run + 1 : 0;
        // Chip model: busy for the first busy_n polls of the current request.
        if (rd_run == 1) begin
            polls_seen++;
            if (req_q.size() == 0)
                chk("unexpected_poll", 1, 0);
            else
                Dout = {(polls_seen <= req_q[0].busy_n), 7'($urandom)};
        end else if (!rd && !was_rd) begin
            Dout = 'x;
        end
        if (wr) begin
            if (req_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                h = req_q[0];
                if (!A0) begin
                    chk("addr_write_expected", {31'b0, h.addr_wr && !h.addr_seen}, 1);
                    chk("addr_din", Din, h.addr);
                    chk("addr_before_polls", polls_seen, 0);
                    h.addr_seen = 1;
                    h.t_addr = cyc;
                    req_q[0] = h;
                    addr_writes++;
                end else begin
                    exp_polls = ((h.busy_n > BT) ? BT : h.busy_n) + 1;
                    chk("data_din", Din, h.data);
                    chk("poll_count", polls_seen, exp_polls);
                    chk("addr_phase", {31'b0, h.addr_seen}, {31'b0, h.addr_wr});
                    if (h.addr_seen)
                        chk("addr_to_data_cycles", cyc - h.t_addr, 1 + 3 * exp_polls);
                    if (h.busy_n > BT)
                        model_err = 1;
                    $display("xfer addr=%02h data=%02h polls=%0d forced=%0d", h.addr, h.data,
                             polls_seen, (h.busy_n > BT));
                    void'(req_q.pop_front());
                    polls_seen = 0;
                end
            end
        end
        chk("fifo_level", fifo_level, pushes - pops);
        chk("req_ready", req_ready, (pushes - pops) != FD);
        chk("timeout_err", timeout_err, model_err);
        if (req_q.size() > 0)
            chk("busy_pending", busy, 1);
    endtask

    task automatic cycle();
        req_t h;
        bit   push_now, rst_now, clr_now;
        push_now = req_valid && req_ready && IC_b;
        rst_now  = !IC_b;
        clr_now  = err_clr;
        if (req_valid && !req_ready && IC_b)
            stalls++;
        last_push = push_now;
        if (push_now) begin
            h = '{addr: req_addr, data: req_data, busy_n: next_busy_n, addr_wr: 1,
                  addr_seen: 0, started: 0, t_addr: 0};
`ifdef YM_BUS_WRITER_ADDR_CACHE_EN
            h.addr_wr = !(cache_valid && cache_addr == req_addr);
`endif
            cache_valid = 1;
            cache_addr  = req_addr;
            req_q.push_back(h);
            pushes++;
        end
        @(negedge phiM);
        cyc++;
        if (rst_now) begin
            req_q.delete();
            pushes = 0; pops = 0; polls_seen = 0; rd_run = 0;
            model_err = 0; cache_valid = 0;
        end
        if (clr_now)
            model_err = 0;
        monitor();
        if (pushes - pops > max_level)
            max_level = pushes - pops;
    endtask

    // Leaves req_valid high so callers can stream requests back to back.
    task automatic push_req(input logic [7:0] a, input logic [7:0] d, input int bn);
        int n = 0;
        req_valid = 1; req_addr = a; req_data = d; next_busy_n = bn;
        do begin
            cycle();
            n++;
        end while (!last_push && n < 200);
        if (!last_push)
            chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 0;
        while (req_q.size() != 0 && n < 2000) begin
            cycle();
            n++;
        end
        chk("drain_pending", req_q.size(), 0);
        repeat (GAP + 3) cycle();
        chk("idle_busy", busy, 0);
        chk("idle_level", fifo_level, 0);
    endtask

    initial begin
        int n, snap, exp_aw;
        Dout = 'x;
        IC_b = 0;
        cycle();
        cycle();
        chk("rst_cs", CS_b, 1);
        chk("rst_wr", WR_b, 1);
        chk("rst_rd", RD_b, 1);
        chk("rst_a0", A0, 0);
        chk("rst_din", Din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        IC_b = 1;
        cycle();

        push_req(8'h1B, 8'hC0, 0);
        drain();
        chk("t1_timeout_err", timeout_err, 0);

        push_req(8'h20, 8'h11, 3);
        drain();
        chk("t2_timeout_err", timeout_err, 0);

        push_req(8'h30, 8'h55, 9);
        drain();
        chk("t3_timeout_set", timeout_err, 1);
        err_clr = 1;
        cycle();
        err_clr = 0;
        chk("t3_timeout_clr", timeout_err, 0);

        stalls = 0;
        max_level = 0;
        push_req(8'h40, 8'h00, 9);
        for (int i = 1; i < FD + 2; i++)
            push_req(8'h40 + 8'(i), 8'hA0 + 8'(i), 0);
        drain();
        chk("fill_max_level", max_level, FD);
        chk("fill_stalled", {31'b0, stalls > 0}, 1);
        err_clr = 1;
        cycle();
        err_clr = 0;

        push_req(8'h50, 8'h01, 2);
        push_req(8'h51, 8'h02, 0);
        push_req(8'h52, 8'h03, 0);
        req_valid = 0;
        n = 0;
        while (rd_run != 2 && n < 100) begin
            cycle();
            n++;
        end
        chk("reach_poll_b", rd_run, 2);
        IC_b = 0;
        cycle();
        IC_b = 1;
        chk("mid_rst_cs", CS_b, 1);
        chk("mid_rst_rd", RD_b, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (10) cycle();

        snap = addr_writes;
        push_req(8'h08, 8'h01, 0);
        push_req(8'h08, 8'h02, 0);
        drain();
`ifdef YM_BUS_WRITER_ADDR_CACHE_EN
        exp_aw = 1;
`else
        exp_aw = 2;
`endif
        chk("cache_addr_writes", addr_writes - snap, exp_aw);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 2) == 0) ? 8'h08 + 8'($urandom_range(0, 1)) : 8'($urandom);
            push_req(a, 8'($urandom), int'($urandom_range(0, 5)));
            req_valid = 0;
            if (model_err && $urandom_range(0, 3) == 0)
                err_clr = 1;
            repeat ($urandom_range(0, 3)) begin
                cycle();
                err_clr = 0;
            end
            err_clr = 0;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ym_bus_writer.md
Name: ym_bus_writer

Overview:
- Host-side initiator for the YM2151 CPU bus; the counterpart of the chip's register file.
- Accepts (register address, data) write requests through a valid/ready handshake and buffers them in a FIFO.
- Replays each request on the chip bus: an address write (A0=0), then status-register polling until the busy flag (Dout[7]) clears, then a data write (A0=1).
- Sits between the sound-sequencer logic and the YM2151 core, in the phiM domain.

Parameters:
- FIFO_DEPTH, 8, request FIFO entries; must be a power of 2, at least 2.
- BUSY_TIMEOUT, 255, maximum busy polls per request before the write is forced.
- GAP_CYCLES, 1, idle bus cycles after each data write; at least 1.

Ports:
- phiM  in  1  clock
- IC_b  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept a request
- req_addr  in  8  YM2151 register number
- req_data  in  8  value to write
- Din  out  8  chip data bus
- CS_b  out  1  chip select, active-low
- WR_b  out  1  write strobe, active-low
- RD_b  out  1  read strobe, active-low
- A0  out  1  0 = address cycle, 1 = data cycle
- Dout  in  8  chip status read-back
- busy  out  1  FIFO non-empty or FSM not in IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- timeout_err  out  1  sticky; set when a write was forced after timeout
- err_clr  in  1  clears timeout_err

Behaviour:
- Clocking and reset:
  - Single clock phiM; reset is synchronous, active-low on IC_b.
  - Reset values: FIFO empty, FSM in IDLE, CS_b=WR_b=RD_b=1, A0=0, Din=0, timeout_err=0, fifo_level=0, busy=0, req_ready=1.
  - Reset asserted mid-transaction abandons the transaction immediately. Bus strobes deassert on the next edge.
- All bus outputs are registered, with no combinational path from Dout or req_* to the bus.
- FIFO:
  - Push when req_valid && req_ready; req_ready = !full.
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
  - When full, req_ready=0 and requests are held off by the handshake, so nothing is lost.
- FSM states, one cycle each unless noted:
  - IDLE, FIFO non-empty: pop the head into working registers, go to ADDR_WR.
  - ADDR_WR: CS_b=0, WR_b=0, A0=0, Din=addr. Go to POLL_A.
  - POLL_A: CS_b=0, RD_b=0, A0=0. Go to POLL_B.
  - POLL_B: CS_b=0, RD_b=0. Go to SAMPLE.
  - SAMPLE: bus idle; capture Dout at the end of this cycle.
    - Dout[7]=0: go to DATA_WR.
    - Dout[7]=1 and poll count < BUSY_TIMEOUT: increment the count, go to POLL_A.
    - Dout[7]=1 and poll count = BUSY_TIMEOUT: set timeout_err, go to DATA_WR (forced write).
  - DATA_WR: CS_b=0, WR_b=0, A0=1, Din=data. Clear the poll count, go to RECOVER.
  - RECOVER: bus idle for GAP_CYCLES cycles, then IDLE.
- Latency:
  - With ADDR_WR in cycle k and not busy, DATA_WR is in cycle k+4.
  - Back-to-back requests: 5+GAP_CYCLES cycles from one ADDR_WR to the next, plus the 1 IDLE cycle.
- Idle bus meaning: CS_b=WR_b=RD_b=1; A0 and Din hold their previous values.
- Dout is never sampled except in SAMPLE, so a high-impedance or X Dout elsewhere is ignored.
- timeout_err is sticky. If err_clr and a new timeout occur in the same cycle, set wins.
- busy = (FSM != IDLE) || (fifo_level != 0).

Optional Feature:
- Macro: YM_BUS_WRITER_ADDR_CACHE_EN.
- When defined:
  - The block keeps last_addr plus a valid bit, both cleared by reset.
  - If a popped request's addr equals last_addr and the valid bit is set, IDLE goes directly to POLL_A and ADDR_WR is skipped.
  - last_addr and the valid bit update on every ADDR_WR.
- When undefined: every request issues ADDR_WR, and no cache registers exist.

Test Plan:
- Reset, then push addr=0x1B data=0xC0, Dout[7]=0: bus shows ADDR_WR Din=0x1B A0=0, DATA_WR 4 cycles later with Din=0xC0 A0=1; busy falls after RECOVER; timeout_err=0.
- Push 0x20/0x11, hold Dout=0x80 for 3 SAMPLE cycles, then 0x00: exactly 4 poll sequences; DATA_WR follows the 4th SAMPLE; no WR_b strobe occurs while busy.
- BUSY_TIMEOUT=3, Dout stuck at 0x80: after 4 SAMPLEs the data write is forced and timeout_err=1; err_clr pulse gives timeout_err=0 next cycle.
- Push FIFO_DEPTH+2 requests with req_valid held high: req_ready=0 at fifo_level=8; all 10 requests appear on the bus in order, each with its own addr/data.
- Assert IC_b=0 during POLL_B: next cycle CS_b=RD_b=1, fifo_level=0, FSM in IDLE, no DATA_WR issued.
- With ADDR_CACHE_EN defined, push 0x08/0x01 then 0x08/0x02: second request shows no A0=0 write strobe; with the macro undefined, two address writes appear.
